// File: rtl/be8_ctrl_pkg.sv
// Shared definitions for the BE8 control sequencer: state encoding, control-line
// bit positions and the idle/fetch control words.
package be8_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_S = 2'd1,
    HALT  = 2'd2
  } seq_state_e;

  localparam int CTRL_W = 17;

  // Bit positions in the control word; _N lines are active-low
  localparam int CB_J_N  = 0;
  localparam int CB_HLT  = 1;
  localparam int CB_CE   = 2;
  localparam int CB_MI_N = 3;
  localparam int CB_RI_N = 4;
  localparam int CB_RO_N = 5;
  localparam int CB_II_N = 6;
  localparam int CB_IO_N = 7;
  localparam int CB_AI_N = 8;
  localparam int CB_AO_N = 9;
  localparam int CB_EO_N = 10;
  localparam int CB_SU_N = 11;
  localparam int CB_BI_N = 12;
  localparam int CB_OI_N = 13;
  localparam int CB_CO_N = 14;
  localparam int CB_FI_N = 15;
  localparam int CB_BO_N = 16;

  localparam logic [CTRL_W-1:0] CTRL_IDLE = 17'h1_FFF9;

  // PC out, MAR in
  localparam logic [CTRL_W-1:0] FETCH0_WORD =
    CTRL_IDLE & ~((17'h1 << CB_CO_N) | (17'h1 << CB_MI_N));

  // RAM out, IR in, PC increment
  localparam logic [CTRL_W-1:0] FETCH1_WORD =
    (CTRL_IDLE & ~((17'h1 << CB_RO_N) | (17'h1 << CB_II_N))) | (17'h1 << CB_CE);

endpackage

// File: rtl/ss_edge_detect.sv
// Rising-edge detector for the single-step request, sampled on the falling clock
// edge so it lines up with the sequencer's state updates.
module ss_edge_detect (
  input  logic CLK,
  input  logic RESETn,
  input  logic STEP,
  output logic RISE
);

  logic step_prev_r;

  // Previous falling-edge sample of STEP
  always_ff @(negedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      step_prev_r <= 1'b0;
    end else begin
      step_prev_r <= STEP;
    end
  end

  assign RISE = STEP & ~step_prev_r;

endmodule

// File: rtl/control_seq.sv
// BE8 control sequencer: two fixed fetch steps followed by microcode-driven execute
// steps, with early termination, per-instruction flag latch, halt and single-step.
module control_seq #(
  parameter int                STEP_W      = 3,
  parameter int                MAX_STEPS   = 6,
  parameter int                NFLAGS      = 2,
  parameter int                CTRL_W      = be8_ctrl_pkg::CTRL_W,
  parameter logic [CTRL_W-1:0] CTRL_IDLE   = be8_ctrl_pkg::CTRL_IDLE,
  parameter logic [CTRL_W-1:0] FETCH0_WORD = be8_ctrl_pkg::FETCH0_WORD,
  parameter logic [CTRL_W-1:0] FETCH1_WORD = be8_ctrl_pkg::FETCH1_WORD
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              RUN,
  input  logic              SSMODE,
  input  logic              STEP,
  input  logic [NFLAGS-1:0] FLAGS,
  input  logic [CTRL_W-1:0] M_CTRL,
  input  logic              M_LAST,
  input  logic              M_HLT,
  output logic [STEP_W-1:0] MSTEP,
  output logic [NFLAGS-1:0] LFLAGS,
  output logic [CTRL_W-1:0] CTRL,
  output logic              T0,
  output logic              HALTED
);

  import be8_ctrl_pkg::*;

  if (MAX_STEPS < 3 || MAX_STEPS > (1 << STEP_W)) begin : g_bad_cfg
    $error("control_seq: MAX_STEPS must lie in 3..2**STEP_W");
  end

  localparam logic [STEP_W-1:0] STEP_ZERO = STEP_W'(0);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  localparam logic [STEP_W-1:0] EXEC0     = STEP_W'(2);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);

  seq_state_e        state_r;
  logic [STEP_W-1:0] step_r;
  logic [NFLAGS-1:0] lflags_r;
  logic              step_rise_s;
  logic              exec_s;
  logic              instr_end_s;

  ss_edge_detect u_ss_edge (
    .CLK    (CLK),
    .RESETn (RESETn),
    .STEP   (STEP),
    .RISE   (step_rise_s)
  );

  assign exec_s      = (state_r == RUN_S) && (step_r >= EXEC0);
  assign instr_end_s = M_LAST || (step_r == LAST_STEP);

  // Sequencer state, microstep counter and per-instruction flag latch
  always_ff @(negedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_r  <= IDLE;
      step_r   <= STEP_ZERO;
      lflags_r <= {NFLAGS{1'b0}};
    end else if (!RUN) begin
      state_r <= IDLE;
      step_r  <= STEP_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          step_r <= STEP_ZERO;
          if (!SSMODE || step_rise_s) begin
            state_r <= RUN_S;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN_S: begin
          if (!exec_s) begin
            // Flags are captured once, leaving the second fetch step
            if (step_r == STEP_ONE) begin
              lflags_r <= FLAGS;
            end else begin
              lflags_r <= lflags_r;
            end
            step_r <= step_r + STEP_ONE;
          end else if (M_HLT) begin
            state_r <= HALT;
            step_r  <= STEP_ZERO;
          end else if (instr_end_s) begin
            step_r  <= STEP_ZERO;
            state_r <= SSMODE ? IDLE : RUN_S;
          end else begin
            step_r <= step_r + STEP_ONE;
          end
        end
        HALT: begin
          state_r <= HALT;
          step_r  <= STEP_ZERO;
        end
        default: begin
          state_r <= IDLE;
          step_r  <= STEP_ZERO;
        end
      endcase
    end
  end

  // Control word: fetch constants, live microcode in execute, idle otherwise
  always_comb begin
    CTRL = CTRL_IDLE;
    if (!RESETn) begin
      CTRL = CTRL_IDLE;
    end else if (state_r == RUN_S) begin
      case (step_r)
        STEP_ZERO: CTRL = FETCH0_WORD;
        STEP_ONE:  CTRL = FETCH1_WORD;
        default:   CTRL = M_CTRL;
      endcase
    end else begin
      CTRL = CTRL_IDLE;
    end
  end

  assign T0     = (state_r == IDLE) || ((state_r == RUN_S) && (step_r == STEP_ZERO));
  assign HALTED = (state_r == HALT);
  assign MSTEP  = exec_s ? (step_r - EXEC0) : STEP_ZERO;
  assign LFLAGS = lflags_r;

endmodule
